pmux_ctrl: RTL and testbench
============================

# pmux_ctrl

Port-A pin-function controller. Holds CPU-programmable per-pin function selects and drives the port multiplexer's configuration inputs. Reassigns pins one at a time through a glitch-free sequence: isolate (hi-Z), guard delay, apply. Sits on the nanorv32 peripheral bus beside the GPIO and UART blocks.

## Interface
- CHIP_PORT_A_WIDTH, 16: number of port-A pins (1..16).
- RESET_GUARD, 4: reset value of the GUARD register, in cycles (0..255).
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- cpu_pmux_req  input  1  bus access request, one cycle per access
- cpu_pmux_we  input  1  1 = write, 0 = read
- cpu_pmux_addr  input  4  byte address; bits [3:2] select the register
- cpu_pmux_wdata  input  32  write data
- pmux_cpu_rdata  output  32  read data, registered
- pmux_cpu_ready  output  1  tied high; every request is accepted in its cycle
- ctrl_pmux_fsel  output  2*W  applied function per pin; pin i uses bits [2i+1:2i]
- ctrl_pmux_tx_sel  output  W  one-hot: pin carrying uart_pad_tx, or all zero
- ctrl_pmux_rx_sel  output  W  one-hot: pin feeding pad_uart_rx, or all zero
- ctrl_busy  output  1  high when pending != 0 or the FSM is not IDLE

## Operation
- Function codes: 0 GPIO, 1 UART_TX, 2 UART_RX, 3 HIZ (ie = oe = 0).
- Registers:
  - 0x0 FSEL (rw): requested codes; reading returns requested, not applied.
  - 0x4 STATUS (ro except bit 3):
    - bit0 busy
    - bit1 tx_conflict (more than one pin requests TX)
    - bit2 rx_conflict
    - bit3 lock_err (sticky, write 1 to clear)
    - [31:16] pending mask
  - 0x8 LOCK: writing bit0 = 1 sets lock until reset; a write of 0 has no effect.
  - 0xC GUARD [7:0] (rw).
- Writes to FSEL or GUARD while locked are ignored and set lock_err. Reads of unused bits return 0.
- pending[i] = (requested[i] != applied[i]). Computed combinationally; never stored.
- FSM states:
  - IDLE: if pending != 0, latch idx = lowest set pending bit, set applied[idx] <= HIZ, cnt <= GUARD, go to GUARD.
  - GUARD: if cnt == 0 go to APPLY, else decrement cnt.
  - APPLY: applied[idx] <= requested[idx] (the latest value), go to IDLE.
- If requested[idx] changes during GUARD, APPLY takes the new value. If it changes back to the old applied value, APPLY still restores that value after the guard.
- GUARD register writes take effect at the next IDLE latch, not mid-count.
- tx_sel / rx_sel = lowest-index pin whose applied code is TX / RX. Additional pins with the same code behave as HIZ: their fsel field is forced to 3 on output.
- Reset values:
  - requested = applied = 0 (all GPIO); ctrl_pmux_fsel = 0
  - tx_sel = rx_sel = 0; ctrl_busy = 0
  - GUARD = RESET_GUARD; lock = 0; lock_err = 0
  - rdata = 0; FSM = IDLE

## Timing
- Write accepted in cycle 0; requested is visible from cycle 1.
- Read of cycle 0 returns data in cycle 1 and reflects state before any cycle-0 write.
- Single-pin change with guard G:
  - IDLE latch in cycle 1; hi-Z visible cycles 2 .. G+3.
  - New code visible from cycle G+4.
  - G = 4: hi-Z in cycles 2-7, new code from cycle 8.
- N pending pins are serviced in ascending index, G+3 cycles each. No idle gap between pins: APPLY → IDLE → latch of the next pin in consecutive cycles.
- Async reset mid-sequence: all outputs return to reset values immediately. The isolated pin becomes GPIO, not its old function.
- ctrl_busy changes in the same cycle as the FSM/pending update.

## Structure
- Function codes, register offsets and FSM encodings go in chip_params.v, shared with port_mux.
- One sub-module: pmux_prio_enc, a lowest-set-bit encoder with parameter W and outputs index + valid. Instantiated three times (pending, TX owner, RX owner).
- Register file and FSM live in pmux_ctrl.

## Test plan
- Reset, then read all registers → FSEL = 0, STATUS = 0, LOCK = 0, GUARD = 4; fsel out = 0; busy = 0.
- Write FSEL = 0x0000_0001 (pin0 TX) → pin0 fsel = 3 in cycles 2-7, = 1 from cycle 8; tx_sel = 0x0001 from cycle 8; busy falls in cycle 8.
- Write FSEL = 0x0000_0024 (pin1 TX, pin2 RX), GUARD = 0 → pin1 applied at cycle 4, pin2 at cycle 7; pending is 0x6, then 0x4, then 0.
- Request TX on pins 3 and 5 → STATUS.tx_conflict = 1; tx_sel = 0x0008; pin5 fsel out = 3.
- Write LOCK = 1, then FSEL = 0xFFFF_FFFF → FSEL unchanged, lock_err = 1; write STATUS bit3 = 1 → lock_err = 0, lock still set.
- Assert rst during GUARD of a pin0 change → fsel out = 0, busy = 0 within the reset cycle; no change is applied after release.

Source files
------------

// File: rtl/pmux_ctrl_pkg.sv
// pmux_ctrl_pkg: function codes, register map and FSM states shared by the port-A pin-mux control path
package pmux_ctrl_pkg;
    localparam logic [1:0] FN_GPIO = 2'd0;
    localparam logic [1:0] FN_TX   = 2'd1;
    localparam logic [1:0] FN_RX   = 2'd2;
    localparam logic [1:0] FN_HIZ  = 2'd3;
    localparam logic [1:0] REG_FSEL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_LOCK   = 2'd2;
    localparam logic [1:0] REG_GUARD  = 2'd3;
    typedef enum logic [1:0] {ST_IDLE, ST_GUARD, ST_APPLY} state_t;
endpackage

// File: rtl/pmux_ctrl_if.sv
// pmux_ctrl_if: nanorv32 peripheral bus slice between the CPU and the pin-mux controller
interface pmux_ctrl_if;
    logic        cpu_pmux_req;
    logic        cpu_pmux_we;
    logic [3:0]  cpu_pmux_addr;
    logic [31:0] cpu_pmux_wdata;
    logic [31:0] pmux_cpu_rdata;
    logic        pmux_cpu_ready;
    modport master (output cpu_pmux_req, cpu_pmux_we, cpu_pmux_addr, cpu_pmux_wdata,
                    input pmux_cpu_rdata, pmux_cpu_ready);
    modport slave  (input cpu_pmux_req, cpu_pmux_we, cpu_pmux_addr, cpu_pmux_wdata,
                    output pmux_cpu_rdata, pmux_cpu_ready);
endinterface

// File: rtl/pmux_ctrl_prio_enc.sv
// pmux_prio_enc: lowest-set-bit encoder, index plus valid
module pmux_prio_enc #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_vec,
    output logic [3:0]   o_idx,
    output logic         o_valid
);
    always_comb begin
        o_idx = '0;
        for (int k = W - 1; k >= 0; k--) if (i_vec[k]) o_idx = 4'(k);
    end
    assign o_valid = |i_vec;
endmodule

// File: rtl/pmux_ctrl.sv
// pmux_ctrl: port-A pin-function controller; CPU-visible selects applied one pin at a time
// through isolate (hi-Z), guard delay, apply.
module pmux_ctrl
    import pmux_ctrl_pkg::*;
#(
    parameter int         CHIP_PORT_A_WIDTH = 16,
    parameter logic [7:0] RESET_GUARD       = 8'd4
) (
    input  logic                           clk,
    input  logic                           rst,
    pmux_ctrl_if.slave                     bus,
    output logic [2*CHIP_PORT_A_WIDTH-1:0] ctrl_pmux_fsel,
    output logic [CHIP_PORT_A_WIDTH-1:0]   ctrl_pmux_tx_sel,
    output logic [CHIP_PORT_A_WIDTH-1:0]   ctrl_pmux_rx_sel,
    output logic                           ctrl_busy
);
    localparam int W = CHIP_PORT_A_WIDTH;

    logic [2*W-1:0] r_req, r_app, w_app_nx;
    logic [7:0]     r_guard, r_cnt, w_cnt_nx;
    logic [3:0]     r_idx, w_idx_nx;
    logic           r_lock, r_lock_err;
    logic [31:0]    r_rdata, w_rd_val;
    state_t         r_state, w_state_nx;
    logic [W-1:0]   w_pending, w_req_tx, w_req_rx, w_app_tx, w_app_rx;
    logic [3:0]     w_pidx, w_tx_idx, w_rx_idx;
    logic           w_pvalid, w_tx_v, w_rx_v, w_tx_conflict, w_rx_conflict;
    logic           w_wr, w_rd, w_cfg_wr, w_lock_viol;
    logic [1:0]     w_sel;
    logic           w_unused;

    assign w_sel       = bus.cpu_pmux_addr[3:2];
    assign w_wr        = bus.cpu_pmux_req && bus.cpu_pmux_we;
    assign w_rd        = bus.cpu_pmux_req && !bus.cpu_pmux_we;
    assign w_cfg_wr    = w_wr && (w_sel == REG_FSEL || w_sel == REG_GUARD);
    assign w_lock_viol = w_cfg_wr && r_lock;
    assign w_unused    = &{1'b0, bus.cpu_pmux_addr[1:0], bus.cpu_pmux_wdata, w_tx_v, w_rx_v};

    for (genvar g = 0; g < W; g++) begin : g_pin
        assign w_pending[g] = r_req[2*g+:2] != r_app[2*g+:2];
        assign w_req_tx[g]  = r_req[2*g+:2] == FN_TX;
        assign w_req_rx[g]  = r_req[2*g+:2] == FN_RX;
        assign w_app_tx[g]  = r_app[2*g+:2] == FN_TX;
        assign w_app_rx[g]  = r_app[2*g+:2] == FN_RX;
        assign ctrl_pmux_tx_sel[g] = w_app_tx[g] && w_tx_idx == 4'(g);
        assign ctrl_pmux_rx_sel[g] = w_app_rx[g] && w_rx_idx == 4'(g);
        // losing owners of a shared UART function are isolated rather than driven
        assign ctrl_pmux_fsel[2*g+:2] = (w_app_tx[g] && !ctrl_pmux_tx_sel[g]) ||
                                        (w_app_rx[g] && !ctrl_pmux_rx_sel[g]) ? FN_HIZ : r_app[2*g+:2];
    end

    pmux_prio_enc #(.W(W)) u_pend (.i_vec(w_pending), .o_idx(w_pidx),   .o_valid(w_pvalid));
    pmux_prio_enc #(.W(W)) u_tx   (.i_vec(w_app_tx),  .o_idx(w_tx_idx), .o_valid(w_tx_v));
    pmux_prio_enc #(.W(W)) u_rx   (.i_vec(w_app_rx),  .o_idx(w_rx_idx), .o_valid(w_rx_v));

    assign w_tx_conflict = |(w_req_tx & (w_req_tx - W'(1)));
    assign w_rx_conflict = |(w_req_rx & (w_req_rx - W'(1)));
    assign ctrl_busy     = w_pvalid || r_state != ST_IDLE;
    assign bus.pmux_cpu_ready = 1'b1;
    assign bus.pmux_cpu_rdata = r_rdata;

    assign w_rd_val = w_sel == REG_FSEL   ? 32'(r_req) :
                      w_sel == REG_STATUS ? {16'(w_pending), 12'd0, r_lock_err, w_rx_conflict, w_tx_conflict, ctrl_busy} :
                      w_sel == REG_LOCK   ? {31'd0, r_lock} : {24'd0, r_guard};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req      <= '0;
            r_guard    <= RESET_GUARD;
            r_lock     <= 1'b0;
            r_lock_err <= 1'b0;
            r_rdata    <= '0;
        end else begin
            if (w_wr && w_sel == REG_FSEL && !r_lock) r_req <= bus.cpu_pmux_wdata[2*W-1:0];
            if (w_wr && w_sel == REG_GUARD && !r_lock) r_guard <= bus.cpu_pmux_wdata[7:0];
            if (w_wr && w_sel == REG_LOCK && bus.cpu_pmux_wdata[0]) r_lock <= 1'b1;
            if (w_lock_viol) r_lock_err <= 1'b1;
            else if (w_wr && w_sel == REG_STATUS && bus.cpu_pmux_wdata[3]) r_lock_err <= 1'b0;
            if (w_rd) r_rdata <= w_rd_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_app   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            r_app   <= w_app_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_idx_nx   = r_idx;
        w_app_nx   = r_app;
        case (r_state)
            ST_IDLE: if (w_pvalid) begin
                w_idx_nx               = w_pidx;
                w_app_nx[2*w_pidx+:2]  = FN_HIZ;
                w_cnt_nx               = r_guard;
                w_state_nx             = ST_GUARD;
            end
            ST_GUARD: if (r_cnt == 8'd0) w_state_nx = ST_APPLY;
                      else w_cnt_nx = r_cnt - 8'd1;
            ST_APPLY: begin
                w_app_nx[2*r_idx+:2] = r_req[2*r_idx+:2];
                w_state_nx           = ST_IDLE;
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_pmux_ctrl.sv
// tb_pmux_ctrl: scoreboard bench for pmux_ctrl; expected read data and per-cycle outputs are queued
// when stimulus is driven and popped when the DUT produces them.
module tb_pmux_ctrl;
    import pmux_ctrl_pkg::*;
    localparam int W = 16;
    localparam logic [3:0] A_FSEL = 4'h0, A_STATUS = 4'h4, A_LOCK = 4'h8, A_GUARD = 4'hC;

    typedef struct packed {
        logic [31:0] f;
        logic [15:0] t;
        logic        b;
    } obs_t;
    typedef struct {
        logic        we;
        logic [3:0]  a;
        logic [31:0] d;
    } op_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [2*W-1:0] fsel;
    logic [W-1:0]   tx_sel, rx_sel;
    logic           busy;
    int             errors = 0;
    int             checks = 0;
    logic [31:0]    rd_q[$];
    obs_t           out_q[$];

    always #5 clk = ~clk;

    pmux_ctrl_if bus();

    pmux_ctrl #(.CHIP_PORT_A_WIDTH(W), .RESET_GUARD(8'd4)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .ctrl_pmux_fsel(fsel), .ctrl_pmux_tx_sel(tx_sel),
        .ctrl_pmux_rx_sel(rx_sel), .ctrl_busy(busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        bus.cpu_pmux_req = 1'b0;
        bus.cpu_pmux_we  = 1'b0;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        bus.cpu_pmux_req = 1'b1; bus.cpu_pmux_we = 1'b1;
        bus.cpu_pmux_addr = a;   bus.cpu_pmux_wdata = d;
        tick;
        bus.cpu_pmux_req = 1'b0; bus.cpu_pmux_we = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [31:0] exp);
        rd_q.push_back(exp);
        bus.cpu_pmux_req = 1'b1; bus.cpu_pmux_we = 1'b0; bus.cpu_pmux_addr = a;
        tick;
        bus.cpu_pmux_req = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] e;
        logic [31:0] exp_reg[4] = '{32'h0, 32'h0, 32'h0, 32'h4};
        do_reset;
        checks++; if (fsel !== '0)   begin errors++; $display("FAIL reset_fsel got %h want 0", fsel); end
        checks++; if (tx_sel !== '0) begin errors++; $display("FAIL reset_tx got %h want 0", tx_sel); end
        checks++; if (rx_sel !== '0) begin errors++; $display("FAIL reset_rx got %h want 0", rx_sel); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (bus.pmux_cpu_ready !== 1'b1) begin errors++; $display("FAIL ready got %b want 1", bus.pmux_cpu_ready); end
        for (int i = 0; i < 4; i++) begin
            bus_read(4'(i * 4), exp_reg[i]);
            e = rd_q.pop_front();
            checks++;
            if (bus.pmux_cpu_rdata !== e) begin errors++; $display("FAIL reset_reg%0d got %h want %h", i, bus.pmux_cpu_rdata, e); end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] e;
        bus_write(A_GUARD, 32'hABCD_015A);
        bus_read(A_GUARD, 32'h0000_005A);
        e = rd_q.pop_front();
        checks++; if (bus.pmux_cpu_rdata !== e) begin errors++; $display("FAIL b2b_guard got %h want %h", bus.pmux_cpu_rdata, e); end
        bus_read(A_LOCK, 32'h0);
        e = rd_q.pop_front();
        checks++; if (bus.pmux_cpu_rdata !== e) begin errors++; $display("FAIL b2b_lock got %h want %h", bus.pmux_cpu_rdata, e); end
    endtask

    task automatic test_single_pin;
        localparam int G = 4;
        obs_t e;
        logic [31:0] r;
        do_reset;
        bus_write(A_FSEL, 32'h1);
        for (int k = 1; k <= 12; k++)
            out_q.push_back('{f: (k < 2) ? 32'h0 : (k <= G + 3) ? 32'h3 : 32'h1,
                              t: (k >= G + 4) ? 16'h1 : 16'h0, b: k < G + 4});
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            e = out_q.pop_front();
            checks++; if (fsel !== e.f)   begin errors++; $display("FAIL pin0_fsel c%0d got %h want %h", k, fsel, e.f); end
            checks++; if (tx_sel !== e.t) begin errors++; $display("FAIL pin0_tx c%0d got %h want %h", k, tx_sel, e.t); end
            checks++; if (busy !== e.b)   begin errors++; $display("FAIL pin0_busy c%0d got %b want %b", k, busy, e.b); end
        end
        bus_read(A_FSEL, 32'h1);
        r = rd_q.pop_front();
        checks++; if (bus.pmux_cpu_rdata !== r) begin errors++; $display("FAIL pin0_fsel_rd got %h want %h", bus.pmux_cpu_rdata, r); end
    endtask

    task automatic test_zero_guard;
        logic [31:0] f_t[8] = '{32'h0, 32'hC, 32'hC, 32'h4, 32'h34, 32'h34, 32'h24, 32'h24};
        logic [15:0] p_t[8] = '{16'h6, 16'h6, 16'h6, 16'h4, 16'h4, 16'h4, 16'h0, 16'h0};
        logic [15:0] t_t[8] = '{16'h0, 16'h0, 16'h0, 16'h2, 16'h2, 16'h2, 16'h2, 16'h2};
        logic [15:0] x_t[8] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h4, 16'h4};
        logic        b_t[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] e;
        do_reset;
        bus_write(A_GUARD, 32'h0);
        bus_write(A_FSEL, 32'h24);
        bus.cpu_pmux_req = 1'b1; bus.cpu_pmux_we = 1'b0; bus.cpu_pmux_addr = A_STATUS;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checks++; if (fsel !== f_t[c-1])   begin errors++; $display("FAIL g0_fsel c%0d got %h want %h", c, fsel, f_t[c-1]); end
            checks++; if (tx_sel !== t_t[c-1]) begin errors++; $display("FAIL g0_tx c%0d got %h want %h", c, tx_sel, t_t[c-1]); end
            checks++; if (rx_sel !== x_t[c-1]) begin errors++; $display("FAIL g0_rx c%0d got %h want %h", c, rx_sel, x_t[c-1]); end
            checks++; if (busy !== b_t[c-1])   begin errors++; $display("FAIL g0_busy c%0d got %b want %b", c, busy, b_t[c-1]); end
            if (c > 1) begin
                e = rd_q.pop_front();
                checks++; if (bus.pmux_cpu_rdata !== e) begin errors++; $display("FAIL g0_status c%0d got %h want %h", c - 1, bus.pmux_cpu_rdata, e); end
            end
            rd_q.push_back({p_t[c-1], 15'd0, b_t[c-1]});
        end
        tick;
        bus.cpu_pmux_req = 1'b0;
        e = rd_q.pop_front();
        checks++; if (bus.pmux_cpu_rdata !== e) begin errors++; $display("FAIL g0_status c8 got %h want %h", bus.pmux_cpu_rdata, e); end
    endtask

    task automatic test_conflict;
        logic [31:0] e;
        int n;
        do_reset;
        bus_write(A_FSEL, 32'h0000_0440);
        bus_read(A_STATUS, 32'h0028_0003);
        e = rd_q.pop_front();
        checks++; if (bus.pmux_cpu_rdata !== e) begin errors++; $display("FAIL conf_status_busy got %h want %h", bus.pmux_cpu_rdata, e); end
        n = 0;
        while (busy && n < 100) begin tick; n++; end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL conf_timeout busy=%b after %0d cycles want 0", busy, n); end
        checks++; if (fsel !== 32'h0000_0C40) begin errors++; $display("FAIL conf_fsel got %h want 00000c40", fsel); end
        checks++; if (tx_sel !== 16'h0008) begin errors++; $display("FAIL conf_tx got %h want 0008", tx_sel); end
        checks++; if (rx_sel !== 16'h0000) begin errors++; $display("FAIL conf_rx got %h want 0000", rx_sel); end
        bus_read(A_STATUS, 32'h0000_0002);
        e = rd_q.pop_front();
        checks++; if (bus.pmux_cpu_rdata !== e) begin errors++; $display("FAIL conf_status got %h want %h", bus.pmux_cpu_rdata, e); end
    endtask

    task automatic test_lock;
        op_t ops[12] = '{
            '{1'b1, A_LOCK,   32'h0},         '{1'b0, A_LOCK,   32'h0},
            '{1'b1, A_LOCK,   32'h1},         '{1'b0, A_LOCK,   32'h1},
            '{1'b1, A_FSEL,   32'hFFFF_FFFF}, '{1'b0, A_FSEL,   32'h0000_0440},
            '{1'b0, A_STATUS, 32'h0000_000A}, '{1'b1, A_GUARD,  32'h9},
            '{1'b0, A_GUARD,  32'h4},         '{1'b1, A_STATUS, 32'h8},
            '{1'b0, A_STATUS, 32'h0000_0002}, '{1'b0, A_LOCK,   32'h1}};
        logic [31:0] e;
        for (int i = 0; i < 12; i++) begin
            if (ops[i].we) bus_write(ops[i].a, ops[i].d);
            else begin
                bus_read(ops[i].a, ops[i].d);
                e = rd_q.pop_front();
                checks++; if (bus.pmux_cpu_rdata !== e) begin errors++; $display("FAIL lock_op%0d got %h want %h", i, bus.pmux_cpu_rdata, e); end
            end
        end
        checks++; if (busy !== 1'b0 || fsel !== 32'h0000_0C40) begin errors++; $display("FAIL lock_hold busy=%b fsel=%h want 0 00000c40", busy, fsel); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] e;
        do_reset;
        bus_write(A_FSEL, 32'h1);
        tick;
        tick;
        checks++; if (fsel !== 32'h3) begin errors++; $display("FAIL mid_hiz got %h want 3", fsel); end
        #2 rst = 1'b1;
        #1;
        checks++; if (fsel !== '0 || busy !== 1'b0 || tx_sel !== '0) begin errors++; $display("FAIL mid_async fsel=%h busy=%b tx=%h want 0", fsel, busy, tx_sel); end
        tick;
        rst = 1'b0;
        for (int i = 0; i < 15; i++) tick;
        checks++; if (fsel !== '0 || busy !== 1'b0) begin errors++; $display("FAIL mid_after fsel=%h busy=%b want 0", fsel, busy); end
        bus_read(A_FSEL, 32'h0);
        e = rd_q.pop_front();
        checks++; if (bus.pmux_cpu_rdata !== e) begin errors++; $display("FAIL mid_fsel_rd got %h want %h", bus.pmux_cpu_rdata, e); end
    endtask

    initial begin
        bus.cpu_pmux_req = 1'b0; bus.cpu_pmux_we = 1'b0;
        bus.cpu_pmux_addr = '0;  bus.cpu_pmux_wdata = '0;
        test_reset;
        test_back_to_back;
        test_single_pin;
        test_zero_guard;
        test_conflict;
        test_lock;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
